sfx_player: RTL and testbench

Parametrised multi-channel tone player generating 50%-duty square waves for the speaker and sound-effect amplifiers. Each channel accepts a note request (frequency in Hz, length in beats), computes its half-period with an iterative divider, and plays it for a beat-quantised duration. A free-running beat tick is shared by all channels. Amplifier gain/shutdown tie-offs stay in the top level.

---
 rtl/sfx_pkg.sv | 15 +
 rtl/sfx_channel.sv | 148 ++++++++++++++
 rtl/sfx_player.sv | 68 ++++++
 tb/tb_sfx_player.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sfx_pkg.sv
// Shared types and constants for the multi-channel square-wave tone player.
package sfx_pkg;

   localparam int unsigned FREQ_W    = 32;
   localparam int unsigned REM_W     = FREQ_W + 1;
   localparam int unsigned DIV_ITERS = 32;
   localparam int unsigned ITER_W    = $clog2(DIV_ITERS);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_PLAY = 2'd2
   } ch_state_e;

endpackage

// File: rtl/sfx_channel.sv
// One tone channel: serial divider for the half period, then a beat-quantised
// 50%-duty square wave until the note length expires or the note is stopped.
module sfx_channel
   import sfx_pkg::*;
#(
   parameter int unsigned CLK_FREQ = 100_000_000,
   parameter int unsigned LEN_W    = 9
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              beat_tick_i,
   input  logic              start_i,
   input  logic              stop_i,
   input  logic [FREQ_W-1:0] freq_i,
   input  logic [LEN_W-1:0]  len_i,
   output logic              tone_o,
   output logic              busy_o,
   output logic              done_c_o
);

   ch_state_e         state_q, state_d;
   logic [ITER_W-1:0] iter_q, iter_d;
   logic [REM_W-1:0]  rem_q, rem_d;
   logic [FREQ_W-1:0] quo_q, quo_d;
   logic [REM_W-1:0]  den_q, den_d;
   logic [LEN_W-1:0]  len_q, len_d;
   logic              rest_q, rest_d;
   logic [FREQ_W-1:0] half_cnt_q, half_cnt_d;
   logic [LEN_W-1:0]  beat_cnt_q, beat_cnt_d;
   logic              fresh_q, fresh_d;
   logic              tone_q, tone_d;
   logic              busy_q;
   logic              done_c;

   logic [REM_W:0]    rem_sh;
   logic [REM_W-1:0]  rem_sub;
   logic              div_ge;
   logic [FREQ_W-1:0] half;
   logic              half_last;

   // Restoring divider step; quo_q shifts the numerator out and the quotient in
   always_comb begin
      rem_sh    = {rem_q, quo_q[FREQ_W-1]};
      div_ge    = (rem_sh >= {1'b0, den_q});
      rem_sub   = REM_W'(rem_sh - {1'b0, den_q});
      half      = (quo_q == '0) ? FREQ_W'(1) : quo_q;
      half_last = (half_cnt_q == (half - FREQ_W'(1)));
   end

   always_comb begin
      state_d    = state_q;
      iter_d     = iter_q;
      rem_d      = rem_q;
      quo_d      = quo_q;
      den_d      = den_q;
      len_d      = len_q;
      rest_d     = rest_q;
      half_cnt_d = half_cnt_q;
      beat_cnt_d = beat_cnt_q;
      fresh_d    = 1'b0;
      tone_d     = tone_q;
      done_c     = 1'b0;

      if (stop_i) begin
         state_d = ST_IDLE;
         tone_d  = 1'b0;
      end else if (start_i) begin
         state_d    = ST_CALC;
         iter_d     = '0;
         rem_d      = '0;
         quo_d      = FREQ_W'(CLK_FREQ);
         den_d      = {freq_i, 1'b0};
         len_d      = len_i;
         rest_d     = (freq_i == '0);
         half_cnt_d = '0;
         tone_d     = 1'b0;
      end else begin
         case (state_q)
            ST_CALC: begin
               quo_d = {quo_q[FREQ_W-2:0], div_ge};
               rem_d = div_ge ? rem_sub : rem_sh[REM_W-1:0];
               if (iter_q == ITER_W'(DIV_ITERS - 1)) begin
                  state_d    = ST_PLAY;
                  beat_cnt_d = len_q;
                  half_cnt_d = '0;
                  fresh_d    = 1'b1;
               end else begin
                  iter_d = iter_q + ITER_W'(1);
               end
            end
            ST_PLAY: begin
               if (half_last) begin
                  half_cnt_d = '0;
                  tone_d     = ~tone_q & ~rest_q;
               end else begin
                  half_cnt_d = half_cnt_q + FREQ_W'(1);
               end
               // A tick on the first PLAY cycle is not counted; len 0 plays forever
               if (beat_tick_i && !fresh_q && (len_q != '0)) begin
                  if (beat_cnt_q == LEN_W'(1)) begin
                     state_d = ST_IDLE;
                     tone_d  = 1'b0;
                     done_c  = 1'b1;
                  end else begin
                     beat_cnt_d = beat_cnt_q - LEN_W'(1);
                  end
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         iter_q     <= '0;
         rem_q      <= '0;
         quo_q      <= '0;
         den_q      <= '0;
         len_q      <= '0;
         rest_q     <= 1'b0;
         half_cnt_q <= '0;
         beat_cnt_q <= '0;
         fresh_q    <= 1'b0;
         tone_q     <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         iter_q     <= iter_d;
         rem_q      <= rem_d;
         quo_q      <= quo_d;
         den_q      <= den_d;
         len_q      <= len_d;
         rest_q     <= rest_d;
         half_cnt_q <= half_cnt_d;
         beat_cnt_q <= beat_cnt_d;
         fresh_q    <= fresh_d;
         tone_q     <= tone_d;
         busy_q     <= (state_d != ST_IDLE);
      end
   end

   assign tone_o   = tone_q;
   assign busy_o   = busy_q;
   assign done_c_o = done_c;

endmodule

// File: rtl/sfx_player.sv
// Multi-channel tone player: shared free-running beat generator plus N_CH
// independent tone channels sliced out of the packed request buses.
module sfx_player
   import sfx_pkg::*;
#(
   parameter int unsigned N_CH      = 2,
   parameter int unsigned CLK_FREQ  = 100_000_000,
   parameter int unsigned BEAT_FREQ = 8,
   parameter int unsigned LEN_W     = 9
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [N_CH-1:0]        start,
   input  logic [N_CH-1:0]        stop,
   input  logic [N_CH*FREQ_W-1:0] freq,
   input  logic [N_CH*LEN_W-1:0]  len,
   output logic [N_CH-1:0]        tone_out,
   output logic [N_CH-1:0]        busy,
   output logic [N_CH-1:0]        done,
   output logic                   beat_tick
);

   localparam int unsigned BEAT_W    = 32;
   localparam int unsigned BEAT_DIV  = CLK_FREQ / BEAT_FREQ;
   localparam int unsigned BEAT_LAST = BEAT_DIV - 1;

   logic [BEAT_W-1:0] beat_cnt_q, beat_cnt_d;
   logic              beat_tick_q;

   // Beat counter never restarts on channel activity, only on reset
   always_comb begin
      beat_cnt_d = beat_cnt_q + BEAT_W'(1);
      if (beat_cnt_q == BEAT_W'(BEAT_LAST)) begin
         beat_cnt_d = '0;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         beat_cnt_q  <= '0;
         beat_tick_q <= 1'b0;
      end else begin
         beat_cnt_q  <= beat_cnt_d;
         beat_tick_q <= (beat_cnt_d == BEAT_W'(BEAT_LAST));
      end
   end

   assign beat_tick = beat_tick_q;

   for (genvar i = 0; i < N_CH; i++) begin : g_ch
      sfx_channel #(
         .CLK_FREQ (CLK_FREQ),
         .LEN_W    (LEN_W)
      ) u_ch (
         .clk         (clk),
         .rst_n       (reset),
         .beat_tick_i (beat_tick_q),
         .start_i     (start[i]),
         .stop_i      (stop[i]),
         .freq_i      (freq[i*FREQ_W +: FREQ_W]),
         .len_i       (len[i*LEN_W +: LEN_W]),
         .tone_o      (tone_out[i]),
         .busy_o      (busy[i]),
         .done_c_o    (done[i])
      );
   end

endmodule

// File: tb/tb_sfx_player.sv
// Scoreboard bench for sfx_player: stimulus queues expected per-channel edge
// events; a negedge monitor pops and compares them as the DUT produces them.
module tb_sfx_player;

   localparam int NCH  = 4;
   localparam int FW   = 32;
   localparam int LW   = 9;
   localparam int BEAT = 100;

   localparam int EV_BON  = 0;
   localparam int EV_BOFF = 1;
   localparam int EV_RISE = 2;
   localparam int EV_FALL = 3;
   localparam int EV_DONE = 4;

   typedef struct {
      int kind;
      int cyc;
   } ev_t;

   logic              clk = 1'b0;
   logic              reset;
   logic [NCH-1:0]    start, stop;
   logic [NCH*FW-1:0] freq;
   logic [NCH*LW-1:0] len;
   logic [NCH-1:0]    tone_out, busy, done;
   logic              beat_tick;

   int  cyc = 0;
   int  r0 = 0;
   int  errors = 0;
   int  checks = 0;
   int  drain_seq = 0;
   int  drain_ack = 0;
   ev_t exp_q[NCH][$];
   logic [NCH-1:0] pb = '0;
   logic [NCH-1:0] pt = '0;

   sfx_player #(
      .N_CH      (NCH),
      .CLK_FREQ  (1000),
      .BEAT_FREQ (10),
      .LEN_W     (LW)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .stop      (stop),
      .freq      (freq),
      .len       (len),
      .tone_out  (tone_out),
      .busy      (busy),
      .done      (done),
      .beat_tick (beat_tick)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- scoreboard helpers ----------------
   task automatic push(input int ch, input int k, input int c);
      ev_t e;
      e.kind = k;
      e.cyc  = c;
      exp_q[ch].push_back(e);
   endtask

   // Expected events of one note started at cycle t with half period h that
   // stops having effect at cycle x_end (tone forced low there).
   task automatic gen_note(input int ch, input int t, input int h, input bit rest,
                           input int x_end, input bit b_on, input bit b_off, input bit dn);
      int n;
      int p;
      n = 0;
      p = t + 33;
      if (b_on) push(ch, EV_BON, t + 1);
      if (!rest) begin
         for (int x = p + h; x <= x_end - 1; x += h) begin
            push(ch, (n % 2 == 0) ? EV_RISE : EV_FALL, x);
            n++;
         end
      end
      if (dn) push(ch, EV_DONE, x_end - 1);
      if (b_off) push(ch, EV_BOFF, x_end);
      if (n % 2 == 1) push(ch, EV_FALL, x_end);
   endtask

   // Cycle of the n-th beat_tick strictly after cycle 'after'
   function automatic int nth_tick(input int after, input int n);
      int c;
      c = after + 1;
      while (((c - r0) % BEAT) != BEAT - 1) c++;
      return c + BEAT * (n - 1);
   endfunction

   task automatic chk_ev(input int ch, input int k);
      ev_t e;
      checks++;
      if (exp_q[ch].size() == 0) begin
         errors++;
         $display("FAIL event ch%0d: got kind %0d at cycle %0d, expected none", ch, k, cyc);
      end else begin
         e = exp_q[ch].pop_front();
         if (e.kind != k || e.cyc != cyc) begin
            errors++;
            $display("FAIL event ch%0d: got kind %0d at cycle %0d, expected kind %0d at cycle %0d",
                     ch, k, cyc, e.kind, e.cyc);
         end
      end
   endtask

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s at cycle %0d: got %0h, expected %0h", nm, cyc, got, exp);
      end
   endtask

   // ---------------- monitor ----------------
   always @(negedge clk) begin
      int  d;
      logic et;
      if (!reset) begin
         chk("reset tone_out", 32'(tone_out), 32'd0);
         chk("reset busy", 32'(busy), 32'd0);
         chk("reset done", 32'(done), 32'd0);
         chk("reset beat_tick", 32'(beat_tick), 32'd0);
         for (int ch = 0; ch < NCH; ch++) exp_q[ch].delete();
         pb = '0;
         pt = '0;
      end else begin
         d  = cyc - r0;
         et = ((d % BEAT) == BEAT - 1);
         chk("beat_tick", 32'(beat_tick), 32'(et));
         for (int ch = 0; ch < NCH; ch++) begin
            if (busy[ch] && !pb[ch]) chk_ev(ch, EV_BON);
            if (!busy[ch] && pb[ch]) chk_ev(ch, EV_BOFF);
            if (tone_out[ch] && !pt[ch]) chk_ev(ch, EV_RISE);
            if (!tone_out[ch] && pt[ch]) chk_ev(ch, EV_FALL);
            if (done[ch]) chk_ev(ch, EV_DONE);
         end
         pb = busy;
         pt = tone_out;
      end
      if (drain_seq != drain_ack) begin
         for (int ch = 0; ch < NCH; ch++) begin
            checks++;
            if (exp_q[ch].size() != 0) begin
               errors++;
               $display("FAIL drain ch%0d: %0d expected events never seen, first kind %0d at cycle %0d",
                        ch, exp_q[ch].size(), exp_q[ch][0].kind, exp_q[ch][0].cyc);
               exp_q[ch].delete();
            end
         end
         drain_ack = drain_seq;
      end
   end

   // ---------------- stimulus ----------------
   task automatic wait_until(input int c);
      while (cyc < c) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic fire(input int ch, input int f, input int l);
      freq[ch*FW +: FW] = 32'(f);
      len[ch*LW +: LW]  = 9'(l);
      start[ch] = 1'b1;
      @(posedge clk);
      #1;
      start[ch] = 1'b0;
   endtask

   initial begin
      int t, d, s, r, c;
      int hs[NCH];
      int fs[NCH];
      hs = '{5, 4, 2, 1};
      fs = '{100, 125, 250, 500};
      start = '0;
      stop  = '0;
      freq  = '0;
      len   = '0;
      reset = 1'b1;
      #1 reset = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b1;
      r0 = cyc;
      wait_until(r0 + 5);

      // Single note: freq 100 -> half 5, 3 beats
      t = cyc;
      d = nth_tick(t + 33, 3);
      gen_note(0, t, 5, 1'b0, d + 1, 1'b1, 1'b1, 1'b1);
      fire(0, 100, 3);
      wait_until(d + 4);

      // Rest: freq 0, 2 beats, tone stays low
      t = cyc;
      d = nth_tick(t + 33, 2);
      gen_note(1, t, 1, 1'b1, d + 1, 1'b1, 1'b1, 1'b1);
      fire(1, 0, 2);
      wait_until(d + 4);

      // Clamp: freq 600 -> half 1, period 2
      t = cyc;
      d = nth_tick(t + 33, 1);
      gen_note(2, t, 1, 1'b0, d + 1, 1'b1, 1'b1, 1'b1);
      fire(2, 600, 1);
      wait_until(d + 4);

      // Continuous: freq 50 -> half 10, len 0, stopped after 600 PLAY cycles
      t = cyc;
      s = t + 33 + 600;
      gen_note(0, t, 10, 1'b0, s + 1, 1'b1, 1'b1, 1'b0);
      fire(0, 50, 0);
      wait_until(s);
      stop[0] = 1'b1;
      @(posedge clk);
      #1;
      stop[0] = 1'b0;
      wait_until(s + 5);

      // Retrigger mid-PLAY: freq 100 len 0, then freq 250 (half 2) len 2
      t = cyc;
      r = t + 33 + 27;
      gen_note(1, t, 5, 1'b0, r + 1, 1'b1, 1'b0, 1'b0);
      fire(1, 100, 0);
      wait_until(r);
      d = nth_tick(r + 33, 2);
      gen_note(1, r, 2, 1'b0, d + 1, 1'b0, 1'b1, 1'b1);
      fire(1, 250, 2);
      wait_until(d + 4);

      // start+stop collision while playing, then while idle, then stop while idle
      t = cyc;
      c = t + 40;
      gen_note(3, t, 5, 1'b0, c + 1, 1'b1, 1'b1, 1'b0);
      fire(3, 100, 2);
      wait_until(c);
      start[3] = 1'b1;
      stop[3]  = 1'b1;
      @(posedge clk);
      #1;
      start[3] = 1'b0;
      stop[3]  = 1'b0;
      wait_until(c + 5);
      start[3] = 1'b1;
      stop     = 4'b1111;
      @(posedge clk);
      #1;
      start = '0;
      stop  = '0;
      wait_until(c + 60);

      // All channels at once: periods 10/8/4/2
      t = cyc;
      d = nth_tick(t + 33, 1);
      for (int ch = 0; ch < NCH; ch++) begin
         gen_note(ch, t, hs[ch], 1'b0, d + 1, 1'b1, 1'b1, 1'b1);
         freq[ch*FW +: FW] = 32'(fs[ch]);
         len[ch*LW +: LW]  = 9'd1;
      end
      start = 4'b1111;
      @(posedge clk);
      #1;
      start = '0;
      wait_until(d + 4);

      drain_seq++;
      repeat (2) @(posedge clk);
      #1;

      // Asynchronous reset mid-note, then beat period restarts from release
      t = cyc;
      c = t + 33 + 57;
      gen_note(0, t, 5, 1'b0, c, 1'b1, 1'b0, 1'b0);
      fire(0, 100, 0);
      wait_until(c);
      #2;
      reset = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b1;
      r0 = cyc;
      wait_until(r0 + 250);

      drain_seq++;
      repeat (2) @(posedge clk);
      #1;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
